mod3_sampler: RTL and testbench

- Streaming ternary sampler for the Encaps path; turns random bytes into N_COEFF coefficients in {0,1,2}.
- Each accepted beat carries LANES bytes; each byte is reduced mod 3.
- Residues go through one register stage, then into a packing buffer. Packed OUT_COEFFS-coefficient words go out over valid/ready.
- Runs one polynomial per start; the default N_COEFF is 700 (HRSS n-1).

---
 rtl/mod3_pkg.sv | 29 ++
 rtl/mod3_byte.sv | 36 +++
 rtl/mod3_sampler.sv | 158 +++++++++++++++
 tb/tb_mod3_sampler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod3_pkg
//  Description : Shared types, residue encodings and sizing helper for the
//                mod-3 ternary sampler (signed output via MOD3_SIGNED_EN).
//  Revision    : 1.0  initial release
// ============================================================================
package mod3_pkg;

    typedef logic [1:0] coeff_t;

    localparam coeff_t MOD3_ZERO = 2'b00;
    localparam coeff_t MOD3_ONE  = 2'b01;
    localparam coeff_t MOD3_TWO  = 2'b10;
    localparam coeff_t MOD3_NEG1 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sampler_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod3_byte.sv
`default_nettype none
// ============================================================================
//  Module      : mod3_byte
//  Description : Combinational byte mod 3 reducer; each nibble is reduced
//                separately (16 = 1 mod 3) and the two residues are folded.
//  Revision    : 1.0  initial release
// ============================================================================
module mod3_byte
    import mod3_pkg::*;
(
    input  logic [7:0] i_byte,
    output coeff_t     o_res
);

    function automatic logic [1:0] nib_mod3(input logic [3:0] n);
        case (n)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: return 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       return 2'd1;
            default:                              return 2'd2;
        endcase
    endfunction

    logic [2:0] w_sum;

    assign w_sum = {1'b0, nib_mod3(i_byte[7:4])} + {1'b0, nib_mod3(i_byte[3:0])};

    always_comb begin
        case (w_sum)
            3'd1, 3'd4: o_res = MOD3_ONE;
            3'd2:       o_res = MOD3_TWO;
            default:    o_res = MOD3_ZERO;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mod3_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : mod3_sampler
//  Description : Streaming ternary sampler: bytes -> mod-3 coefficients,
//                one s1 register stage, packer, valid/ready output word.
//                Define MOD3_SIGNED_EN for centred two's complement output.
//  Revision    : 1.0  initial release
// ============================================================================
module mod3_sampler
    import mod3_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int OUT_COEFFS = 10,
    parameter int N_COEFF    = 700
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*LANES-1:0]      in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2*OUT_COEFFS-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int N_WORDS = ceil_div(N_COEFF, OUT_COEFFS);
    localparam int CNT_W   = $clog2(N_COEFF + 1);
    localparam int FILL_W  = $clog2(OUT_COEFFS + 1);
    localparam int FW1     = FILL_W + 1;
    localparam int WORD_W  = $clog2(N_WORDS + 1);

    sampler_state_t          r_state;
    logic [CNT_W-1:0]        r_accept_cnt;
    logic                    r_s1_valid;
    logic [2*LANES-1:0]      r_s1_data;
    logic [2*LANES-1:0]      w_res;
    logic [FILL_W-1:0]       r_fill;
    logic [FILL_W-1:0]       w_base;
    logic [FILL_W-1:0]       w_fill_next;
    logic [2*OUT_COEFFS-1:0] r_pk_data;
    logic [2*OUT_COEFFS-1:0] w_pk_next;
    logic [WORD_W-1:0]       r_word_cnt;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [2*OUT_COEFFS-1:0] r_out_data;

    logic w_out_free;
    logic w_full;
    logic w_room;
    logic w_xfer;
    logic w_s1_move;
    logic w_accept;
    logic w_restart;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        coeff_t w_raw;
        mod3_byte u_byte (
            .i_byte (in_data[8*j +: 8]),
            .o_res  (w_raw)
        );
`ifdef MOD3_SIGNED_EN
        assign w_res[2*j +: 2] = (w_raw == MOD3_TWO) ? MOD3_NEG1 : w_raw;
`else
        assign w_res[2*j +: 2] = w_raw;
`endif
    end

    assign w_out_free = ~r_out_valid | out_ready;
    assign w_full     = (r_fill == FILL_W'(OUT_COEFFS));
    assign w_room     = ({1'b0, r_fill} + FW1'(LANES)) <= FW1'(OUT_COEFFS);
    // A short tail is only flushed once s1 has drained, so it really is the tail.
    assign w_xfer     = w_out_free &
                        (w_full | ((r_state == FLUSH) & (r_fill != '0) & ~r_s1_valid));
    assign w_s1_move  = r_s1_valid & (w_room | w_xfer);
    assign in_ready   = (r_state == RUN) & (r_accept_cnt < CNT_W'(N_COEFF)) &
                        (~r_s1_valid | w_s1_move);
    assign w_accept   = in_valid & in_ready;
    assign w_restart  = start & ((r_state == IDLE) | (r_state == DONE));

    always_comb begin
        w_base    = w_xfer ? '0 : r_fill;
        w_pk_next = w_xfer ? '0 : r_pk_data;
        if (w_s1_move) begin
            for (int j = 0; j < LANES; j++) begin
                w_pk_next[2*(int'(w_base) + j) +: 2] = r_s1_data[2*j +: 2];
            end
        end
        w_fill_next = w_s1_move ? (w_base + FILL_W'(LANES)) : w_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_accept_cnt <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_fill       <= '0;
            r_pk_data    <= '0;
            r_word_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else if (w_restart) begin
            r_state      <= RUN;
            r_accept_cnt <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_fill       <= '0;
            r_pk_data    <= '0;
            r_word_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            case (r_state)
                RUN:     if (r_accept_cnt == CNT_W'(N_COEFF)) r_state <= FLUSH;
                FLUSH:   if (r_out_valid & out_ready & r_out_last) r_state <= DONE;
                default: r_state <= r_state;
            endcase

            if (w_accept) begin
                r_accept_cnt <= r_accept_cnt + CNT_W'(LANES);
            end

            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= w_res;
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end

            r_fill    <= w_fill_next;
            r_pk_data <= w_pk_next;

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_pk_data;
                r_out_last  <= (r_word_cnt == WORD_W'(N_WORDS - 1));
                r_word_cnt  <= r_word_cnt + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state == RUN) | (r_state == FLUSH);
    assign done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mod3_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod3_sampler
//  Description : Self-checking bench for mod3_sampler (default and short-run
//                instances); honours MOD3_SIGNED_EN for expected encodings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod3_sampler;

    localparam int OC = 10;
    localparam int NC = 700;
`ifdef MOD3_SIGNED_EN
    localparam logic [1:0]  E2   = 2'b11;
    localparam logic [19:0] B_W1 = 20'hFFFFF;
    localparam logic [19:0] B_W2 = 20'h000FF;
`else
    localparam logic [1:0]  E2   = 2'b10;
    localparam logic [19:0] B_W1 = 20'hAAAAA;
    localparam logic [19:0] B_W2 = 20'h000AA;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b;
    logic [15:0] in_data_a, in_data_b;
    logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic [19:0] out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b, out_ready_a, out_ready_b;
    logic        out_last_a, out_last_b, busy_a, busy_b, done_a, done_b;

    mod3_sampler u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a)
    );

    mod3_sampler #(.LANES(2), .OUT_COEFFS(10), .N_COEFF(14)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b)
    );

    typedef struct { logic [15:0] data; logic [1:0] e0; logic [1:0] e1; } vec_t;
    typedef struct { logic [19:0] data; logic last; } word_t;

    vec_t        beats[$];
    word_t       exp_q[$];
    vec_t        spot[6];
    word_t       b_exp[2];
    word_t       mon_w;
    int          errors = 0;
    int          checks = 0;
    logic [19:0] m_word;
    int          m_fill, m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        case (v % 3)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return E2;
        endcase
    endfunction

    task automatic model_reset();
        m_word = '0; m_fill = 0; m_total = 0;
    endtask

    task automatic model_push(input logic [1:0] c0, input logic [1:0] c1);
        m_word[2*m_fill +: 2]     = c0;
        m_word[2*m_fill + 2 +: 2] = c1;
        m_fill  += 2;
        m_total += 2;
        if (m_fill == OC || m_total == NC) begin
            exp_q.push_back('{m_word, (m_total == NC)});
            m_word = '0;
            m_fill = 0;
        end
    endtask

    task automatic add_const(input int n, input logic [15:0] d, input logic [1:0] e0, input logic [1:0] e1);
        for (int i = 0; i < n; i++) beats.push_back('{d, e0, e1});
    endtask

    task automatic run_beats(input int max_cycles, output int cycles);
        cycles = 0;
        while (beats.size() > 0 && cycles < max_cycles) begin
            in_valid_a = 1'b1;
            in_data_a  = beats[0].data;
            @(negedge clk);
            if (in_ready_a) begin
                model_push(beats[0].e0, beats[0].e1);
                beats.delete(0);
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid_a = 1'b0;
    endtask

    task automatic do_start_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done_a && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done_a}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Scoreboard and output-hold monitor for the default instance.
    logic        stall_prev = 1'b0;
    logic        stall_last;
    logic [19:0] stall_data;
    logic        last_acc_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev    = 1'b0;
            last_acc_prev = 1'b0;
        end else begin
            if (last_acc_prev) check("done_after_last", {31'd0, done_a}, 32'd1);
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid_a}, 32'd1);
                check("hold_data", {12'd0, out_data_a}, {12'd0, stall_data});
                check("hold_last", {31'd0, out_last_a}, {31'd0, stall_last});
            end
            if (out_valid_a && out_ready_a) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", out_data_a);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("word_data", {12'd0, out_data_a}, {12'd0, mon_w.data});
                    check("word_last", {31'd0, out_last_a}, {31'd0, mon_w.last});
                end
            end
            stall_prev    = out_valid_a && !out_ready_a;
            stall_data    = out_data_a;
            stall_last    = out_last_a;
            last_acc_prev = out_valid_a && out_ready_a && out_last_a;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int n;
        int got;
        logic [15:0] d;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        in_data_a = '0; in_data_b = '0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready_a},  32'd0);
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_out_last",  {31'd0, out_last_a},  32'd0);
        check("rst_out_data",  {12'd0, out_data_a},  32'd0);
        check("rst_busy",      {31'd0, busy_a},      32'd0);
        check("rst_done",      {31'd0, done_a},      32'd0);
        check("rst_b_valid",   {31'd0, out_valid_b}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Run 1: reducer spot table, full byte sweep on lane 0, then filler.
        spot = '{ '{16'h80FF, 2'b00, E2}, '{16'h0007, 2'b01, 2'b00},
                  '{16'h0302, E2, 2'b00},  '{16'h0000, 2'b00, 2'b00},
                  '{16'hFF80, E2, 2'b00},  '{16'h0201, 2'b01, E2} };
        do_start_a();
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 6; i++) beats.push_back(spot[i]);
        for (int i = 0; i < 256; i++) begin
            d = {8'(255 - i), 8'(i)};
            beats.push_back('{d, enc(i), enc(255 - i)});
        end
        add_const(88, 16'h0201, 2'b01, E2);
        run_beats(1000, cyc);
        check("run1_all_accepted", beats.size(), 32'd0);
        wait_done("run1_done", 200);
        check("run1_queue_empty", exp_q.size(), 32'd0);
        check("run1_busy_low", {31'd0, busy_a}, 32'd0);

        // Run 2: back-to-back constant stream, one beat per cycle.
        model_reset();
        do_start_a();
        check("restart_done_low", {31'd0, done_a}, 32'd0);
        add_const(350, 16'h0201, 2'b01, E2);
        run_beats(1000, cyc);
        check("run2_cycles", cyc, 32'd350);
        wait_done("run2_done", 200);
        check("run2_queue_empty", exp_q.size(), 32'd0);

        // Run 3: output backpressure with random bytes.
        model_reset();
        do_start_a();
        out_ready_a = 1'b0;
        for (int i = 0; i < 350; i++) begin
            d = 16'($urandom);
            beats.push_back('{d, enc(int'(d[7:0])), enc(int'(d[15:8]))});
        end
        run_beats(20, cyc);
        got = 350 - beats.size();
        check("bp_accepted", got, 2 * (OC / 2) + 1);
        check("bp_in_ready_low", {31'd0, in_ready_a}, 32'd0);
        out_ready_a = 1'b1;
        run_beats(2000, cyc);
        check("run3_all_accepted", beats.size(), 32'd0);
        wait_done("run3_done", 200);
        check("run3_queue_empty", exp_q.size(), 32'd0);

        // Run 4: reset after 100 beats, then a clean rerun.
        model_reset();
        do_start_a();
        add_const(350, 16'h0201, 2'b01, E2);
        run_beats(100, cyc);
        rst = 1'b1;
        beats.delete();
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  {31'd0, in_ready_a},  32'd0);
        check("abort_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("abort_out_last",  {31'd0, out_last_a},  32'd0);
        check("abort_out_data",  {12'd0, out_data_a},  32'd0);
        check("abort_busy",      {31'd0, busy_a},      32'd0);
        check("abort_done",      {31'd0, done_a},      32'd0);
        @(posedge clk); #1;
        do_start_a();
        add_const(350, 16'h0201, 2'b01, E2);
        run_beats(1000, cyc);
        check("run4_cycles", cyc, 32'd350);
        wait_done("run4_done", 200);
        check("run4_queue_empty", exp_q.size(), 32'd0);

        // Short run on the N_COEFF=14 instance: partial final word.
        b_exp = '{ '{B_W1, 1'b0}, '{B_W2, 1'b1} };
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        got = 0;
        n = 0;
        while (got < 7 && n < 50) begin
            in_valid_b = 1'b1;
            in_data_b  = 16'h0505;
            @(negedge clk);
            if (in_ready_b) got++;
            @(posedge clk); #1;
            n++;
        end
        in_valid_b = 1'b0;
        check("b_beats", got, 32'd7);
        for (int w = 0; w < 2; w++) begin
            n = 0;
            @(negedge clk);
            while (!out_valid_b && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b_word_valid", {31'd0, out_valid_b}, 32'd1);
            check("b_word_data", {12'd0, out_data_b}, {12'd0, b_exp[w].data});
            check("b_word_last", {31'd0, out_last_b}, {31'd0, b_exp[w].last});
            @(posedge clk); #1;
        end
        check("b_done", {31'd0, done_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
